// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and types for the 4x16 register file
package regfile_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 2;
   localparam int NUM_REGS = 2**ADDR_W;

   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational NUM_REGS:1 read mux
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
   import regfile_pkg::*;
(
   input  reg_data_t regs_i [NUM_REGS],
   input  reg_addr_t rd_addr,
   input  logic      rst_n,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  reg_data_t wr_data,
   output reg_data_t rd_data
);

`ifdef REGFILE_BYPASS_EN
   // Forward the writeback value so the ALU sees it in the same cycle it is produced.
   always_comb begin
      rd_data = regs_i[rd_addr];
      if (rst_n && wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{rst_n, wr_en, wr_addr, wr_data};
   assign rd_data       = regs_i[rd_addr];
`endif

endmodule

// File: rtl/register_file_2bit.sv
// rtl/register_file_2bit.sv - 4x16 register file, two combinational reads, one write
// Build option: REGFILE_BYPASS_EN enables write-through forwarding on both read ports.
module register_file_2bit
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      Write,
   input  reg_addr_t AddrA,
   input  reg_addr_t AddrB,
   input  reg_addr_t DestAddr,
   input  reg_data_t DestData,
   output reg_data_t DataA,
   output reg_data_t DataB
);

   reg_data_t regs_q [NUM_REGS];
   reg_data_t regs_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (Write && (DestAddr == reg_addr_t'(i))) begin
            regs_d[i] = DestData;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   regfile_read_port u_port_a (
      .regs_i  (regs_q),
      .rd_addr (AddrA),
      .rst_n   (rst_n),
      .wr_en   (Write),
      .wr_addr (DestAddr),
      .wr_data (DestData),
      .rd_data (DataA)
   );

   regfile_read_port u_port_b (
      .regs_i  (regs_q),
      .rd_addr (AddrB),
      .rst_n   (rst_n),
      .wr_en   (Write),
      .wr_addr (DestAddr),
      .wr_data (DestData),
      .rd_data (DataB)
   );

endmodule

// File: tb/tb_register_file_2bit.sv
// tb/tb_register_file_2bit.sv - randomized and directed bench for register_file_2bit
module tb_register_file_2bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Write;
   logic [1:0]  AddrA, AddrB, DestAddr;
   logic [15:0] DestData;
   logic [15:0] DataA, DataB;

   logic [15:0] mdl [4] = '{default: 16'h0000};
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          cmp_en   = 1'b0;

   register_file_2bit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Write    (Write),
      .AddrA    (AddrA),
      .AddrB    (AddrB),
      .DestAddr (DestAddr),
      .DestData (DestData),
      .DataA    (DataA),
      .DataB    (DataB)
   );

   always #10 clk = ~clk;

   // Reference: array of four words, written on a clock edge outside reset, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mdl[i] <= 16'h0000;
      end else if (Write) begin
         mdl[DestAddr] <= DestData;
      end
   end

   function automatic logic [15:0] exp_rd(input logic [1:0] a);
      logic [15:0] v;
      v = mdl[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && Write && (a == DestAddr)) v = DestData;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_a", DataA, exp_rd(AddrA));
         check("model_b", DataB, exp_rd(AddrB));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; Write = 1'b0; AddrA = '0; AddrB = '0; DestAddr = '0; DestData = '0;
      #1;
      cmp_en = 1'b1;
      repeat (2) tick();
      check("reset_a", DataA, 16'h0000);
      check("reset_b", DataB, 16'h0000);
      rst_n = 1'b1;

      // Fill reg i with i, then sweep every address pair.
      for (int i = 0; i < 4; i++) begin
         Write = 1'b1; DestAddr = 2'(i); DestData = 16'(i);
         tick();
      end
      Write = 1'b0;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            tick();
            AddrA = 2'(a); AddrB = 2'(b);
            #1;
            check("sweep_a", DataA, 16'(a));
            check("sweep_b", DataB, 16'(b));
         end
      end

      Write = 1'b0; DestAddr = 2'd2; DestData = 16'hBEEF;
      repeat (3) tick();
      AddrA = 2'd2;
      #1;
      check("wr_disabled", DataA, 16'h0002);

      // Same-cycle read of the register being written.
      Write = 1'b1; DestAddr = 2'd1; DestData = 16'h0005;
      tick();
      DestData = 16'h00AA; AddrA = 2'd1; AddrB = 2'd1;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("rw_pre_a", DataA, 16'h00AA);
      check("rw_pre_b", DataB, 16'h00AA);
`else
      check("rw_pre_a", DataA, 16'h0005);
      check("rw_pre_b", DataB, 16'h0005);
`endif
      tick();
      Write = 1'b0;
      #1;
      check("rw_post_a", DataA, 16'h00AA);
      check("rw_post_b", DataB, 16'h00AA);

      Write = 1'b1; DestAddr = 2'd3; DestData = 16'hFFFF;
      tick();
      DestData = 16'h8001;
      tick();
      Write = 1'b0; AddrA = 2'd3; AddrB = 2'd0;
      #1;
      check("overwrite", DataA, 16'h8001);
      check("other_r0", DataB, 16'h0000);
      AddrB = 2'd2;
      #1;
      check("other_r2", DataB, 16'h0002);

      // Asynchronous reset mid-cycle, no clock edge needed.
      tick();
      rst_n = 1'b0;
      for (int a = 0; a < 4; a++) begin
         AddrA = 2'(a); AddrB = 2'(3 - a);
         #1;
         check("async_rst_a", DataA, 16'h0000);
         check("async_rst_b", DataB, 16'h0000);
      end
      tick();
      rst_n = 1'b1;
      Write = 1'b1; DestAddr = 2'd0; DestData = 16'h5555;
      tick();
      DestData = 16'h1234;
      #3;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; Write = 1'b0; AddrA = 2'd0;
      tick();
      check("rst_during_wr", DataA, 16'h0000);

      // Randomized traffic, checked each cycle by the model compare.
      for (int n = 0; n < 400; n++) begin
         tick();
         Write    = 1'($urandom_range(0, 1));
         AddrA    = 2'($urandom_range(0, 3));
         AddrB    = 2'($urandom_range(0, 3));
         DestAddr = 2'($urandom_range(0, 3));
         DestData = 16'($urandom);
         rst_n    = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      end
      tick();
      rst_n = 1'b1; Write = 1'b0;
      tick();
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
